// File: rtl/anneal_step_sched.sv
// Job sequencer for the anneal step counter and spin-update datapath.
// Loads the counter, issues one step per handshake, reloads between rounds, reports done/error.
module anneal_step_sched #(
    parameter int unsigned COUNTER_BITWIDTH = 8,
    parameter int unsigned ROUND_BITWIDTH   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic [COUNTER_BITWIDTH-1:0] cfg_iters_i,
    input  logic [ROUND_BITWIDTH-1:0]   cfg_rounds_i,
    input  logic                        abort_i,
    output logic                        step_valid_o,
    input  logic                        step_ready_i,
    output logic                        cnt_en_o,
    output logic                        cnt_load_o,
    output logic [COUNTER_BITWIDTH-1:0] cnt_value_o,
    output logic                        cnt_step_o,
    output logic                        cnt_recount_o,
    input  logic                        cnt_finish_i,
    input  logic                        cnt_overflow_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [ROUND_BITWIDTH-1:0]   round_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StCheck,
        StRecount,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [COUNTER_BITWIDTH-1:0] iters_q, iters_d;
    logic [ROUND_BITWIDTH-1:0]   round_q, round_d;
    logic                        err_q, err_d;

    always_comb begin
        state_d       = state_q;
        iters_d       = iters_q;
        round_d       = round_q;
        err_d         = err_q;
        cfg_ready_o   = 1'b0;
        step_valid_o  = 1'b0;
        cnt_load_o    = 1'b0;
        cnt_step_o    = 1'b0;
        cnt_recount_o = 1'b0;
        done_o        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    iters_d = cfg_iters_i;
                    round_d = cfg_rounds_i;
                    err_d   = 1'b0;
                    if ((cfg_iters_i == '0) || (cfg_rounds_i == '0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                cnt_load_o = 1'b1;
                state_d    = StIssue;
            end
            StIssue: begin
                step_valid_o = 1'b1;
                if (step_ready_i) begin
                    cnt_step_o = 1'b1;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (!cnt_finish_i) begin
                    state_d = StIssue;
                end else if (round_q > ROUND_BITWIDTH'(1)) begin
                    state_d = StRecount;
                end else begin
                    state_d = StDone;
                end
            end
            StRecount: begin
                cnt_recount_o = 1'b1;
                round_d       = round_q - ROUND_BITWIDTH'(1);
                state_d       = StIssue;
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort beats overflow beats the normal transition; both suppress this cycle's strobes.
        if (state_q != StIdle) begin
            if (abort_i) begin
                state_d       = StIdle;
                round_d       = round_q;
                err_d         = err_q;
                cnt_load_o    = 1'b0;
                cnt_step_o    = 1'b0;
                cnt_recount_o = 1'b0;
                done_o        = 1'b0;
            end else if (cnt_overflow_i) begin
                err_d         = 1'b1;
                round_d       = round_q;
                cnt_load_o    = 1'b0;
                cnt_step_o    = 1'b0;
                cnt_recount_o = 1'b0;
                // Already signalling done; finish rather than pulse done twice.
                state_d       = (state_q == StDone) ? StIdle : StDone;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            iters_q <= '0;
            round_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iters_q <= iters_d;
            round_q <= round_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign cnt_en_o    = busy_o;
    assign cnt_value_o = iters_q;
    assign round_o     = round_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_anneal_step_sched.sv
// Scoreboard bench for anneal_step_sched: jobs push expected outcomes, a negedge monitor
// counts strobes per job and compares when done_o fires.
module tb_anneal_step_sched;

    localparam int CW = 8;
    localparam int RW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [CW-1:0] cfg_iters_i = '0;
    logic [RW-1:0] cfg_rounds_i = '0;
    logic          abort_i = 1'b0;
    logic          step_valid_o;
    logic          step_ready_i = 1'b1;
    logic          cnt_en_o;
    logic          cnt_load_o;
    logic [CW-1:0] cnt_value_o;
    logic          cnt_step_o;
    logic          cnt_recount_o;
    logic          cnt_finish_i;
    logic          cnt_overflow_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [RW-1:0] round_o;

    anneal_step_sched #(
        .COUNTER_BITWIDTH(CW),
        .ROUND_BITWIDTH  (RW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_iters_i   (cfg_iters_i),
        .cfg_rounds_i  (cfg_rounds_i),
        .abort_i       (abort_i),
        .step_valid_o  (step_valid_o),
        .step_ready_i  (step_ready_i),
        .cnt_en_o      (cnt_en_o),
        .cnt_load_o    (cnt_load_o),
        .cnt_value_o   (cnt_value_o),
        .cnt_step_o    (cnt_step_o),
        .cnt_recount_o (cnt_recount_o),
        .cnt_finish_i  (cnt_finish_i),
        .cnt_overflow_i(cnt_overflow_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .round_o       (round_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in for the external step counter.
    logic [CW-1:0] env_cnt, env_tgt;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            env_cnt <= '0;
            env_tgt <= '0;
        end else if (cnt_load_o) begin
            env_cnt <= '0;
            env_tgt <= cnt_value_o;
        end else if (cnt_recount_o) begin
            env_cnt <= '0;
        end else if (cnt_step_o) begin
            env_cnt <= env_cnt + 1'b1;
        end
    end
    assign cnt_finish_i = (env_tgt != '0) && (env_cnt == env_tgt);

    bit rand_rdy = 1'b0;
    always @(posedge clk_i) begin
        #1;
        step_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int loads;
        int steps;
        int recounts;
        int lat;
        int err;
    } exp_t;

    exp_t exp_q[$];

    // Reference outcome of one job; lat < 0 means latency is not predicted (backpressure).
    function automatic exp_t model(input int n, input int r, input bit rdy_hi, input int ovf_k);
        exp_t e;
        if (n == 0 || r == 0) begin
            e = '{loads: 0, steps: 0, recounts: 0, lat: 1, err: 0};
        end else if (ovf_k > 0) begin
            e = '{loads: 1, steps: ovf_k - 1, recounts: 0,
                  lat: rdy_hi ? 2 * ovf_k + 1 : -1, err: 1};
        end else begin
            e = '{loads: 1, steps: n * r, recounts: r - 1,
                  lat: rdy_hi ? 1 + 2 * n * r + (r - 1) + 1 : -1, err: 0};
        end
        return e;
    endfunction

    // Monitor: per-job strobe accounting, compared against the scoreboard on done_o.
    int cyc = 0, t_acc = 0, m_loads = 0, m_steps = 0, m_recs = 0, m_hs = 0, cur_rounds = 0;
    bit prev_stall = 1'b0, prev_done = 1'b0;
    always @(negedge clk_i) begin
        exp_t e;
        bit ok;
        int ns;
        cyc++;
        if (!rst_ni) begin
            m_loads = 0; m_steps = 0; m_recs = 0; m_hs = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            ns = int'(cnt_load_o) + int'(cnt_step_o) + int'(cnt_recount_o);
            ok = (cfg_ready_o == !busy_o) && (cnt_en_o == busy_o) && (ns <= 1);
            check("invariant", 32'(ok), 32'd1);
            if (prev_stall) check("valid_held", 32'(step_valid_o), 32'd1);
            if (prev_done) check("ready_after_done", 32'(cfg_ready_o), 32'd1);
            if (cfg_valid_i && cfg_ready_o) begin
                t_acc = cyc;
                m_loads = 0; m_steps = 0; m_recs = 0; m_hs = 0;
                cur_rounds = int'(cfg_rounds_i);
            end
            if (cnt_load_o) m_loads++;
            if (cnt_step_o) m_steps++;
            if (step_valid_o && step_ready_i && !abort_i && !cnt_overflow_i) m_hs++;
            if (cnt_recount_o) begin
                check("round_at_recount", 32'(round_o), 32'(cur_rounds - m_recs));
                m_recs++;
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o=1, expected no done (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("loads", 32'(m_loads), 32'(e.loads));
                    check("steps", 32'(m_steps), 32'(e.steps));
                    check("handshakes", 32'(m_hs), 32'(e.steps));
                    check("recounts", 32'(m_recs), 32'(e.recounts));
                    check("err_at_done", 32'(err_o), 32'(e.err));
                    if (e.lat >= 0) check("done_latency", 32'(cyc - t_acc), 32'(e.lat));
                end
            end
            prev_stall = step_valid_o && !step_ready_i && !abort_i && !cnt_overflow_i;
            prev_done  = done_o;
        end
    end

    function automatic logic [31:0] outs();
        return 32'({cfg_ready_o, step_valid_o, cnt_en_o, cnt_load_o, cnt_step_o, cnt_recount_o,
                    busy_o, done_o, err_o, round_o, cnt_value_o});
    endfunction

    localparam logic [31:0] RESET_OUTS = 32'h0010_0000;  // cfg_ready_o only

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            if (cfg_ready_o) return;
            @(posedge clk_i); #1;
        end
        n_vec++;
        n_fail++;
        $display("FAIL idle_timeout: got cfg_ready_o=0, expected 1 within 5000 cycles");
    endtask

    task automatic accept(input int n, input int r);
        cfg_iters_i  = CW'(n);
        cfg_rounds_i = RW'(r);
        cfg_valid_i  = 1'b1;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        check("accept_err_clear", 32'(err_o), 32'd0);
        check("accept_iters", 32'(cnt_value_o), 32'(n));
        check("accept_rounds", 32'(round_o), 32'(r));
    endtask

    task automatic start_job(input int n, input int r, input bit rdy_hi, input int ovf_k);
        int seen;
        rand_rdy = !rdy_hi;
        wait_idle();
        exp_q.push_back(model(n, r, rdy_hi, ovf_k));
        accept(n, r);
        if (n != 0 && r != 0) check("load_at_t1", 32'(cnt_load_o), 32'd1);
        if (ovf_k > 0) begin
            seen = 0;
            for (int i = 0; i < 200 && seen < ovf_k; i++) begin
                @(posedge clk_i); #1;
                if (step_valid_o) seen++;
            end
            check("ovf_issue_reached", 32'(seen), 32'(ovf_k));
            cnt_overflow_i = 1'b1;
            @(posedge clk_i); #1;
            cnt_overflow_i = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int n, r;
        bit rdy;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", outs(), RESET_OUTS);
        rst_ni = 1'b1;

        start_job(3, 1, 1'b1, 0);
        start_job(2, 3, 1'b1, 0);
        start_job(4, 1, 1'b0, 0);
        start_job(0, 5, 1'b1, 0);
        start_job(5, 0, 1'b1, 0);
        start_job(3, 2, 1'b1, 2);
        start_job(2, 1, 1'b1, 0);

        // Abort while a step is offered and accepted in the same cycle.
        rand_rdy = 1'b0;
        @(posedge clk_i); #1;
        accept(3, 2);
        for (int i = 0; i < 20 && !step_valid_o; i++) begin
            @(posedge clk_i); #1;
        end
        abort_i = 1'b1;
        #1;
        check("abort_no_step", 32'(cnt_step_o), 32'd0);
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        check("abort_idle", 32'({cfg_ready_o, busy_o, step_valid_o, done_o}), 32'b1000);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        check("abort_ignored_idle", 32'(cfg_ready_o), 32'd1);

        // Asynchronous reset in the middle of a recount.
        accept(1, 3);
        for (int i = 0; i < 20 && !cnt_recount_o; i++) begin
            @(posedge clk_i); #1;
        end
        check("recount_reached", 32'(cnt_recount_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs", outs(), RESET_OUTS);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        for (int k = 0; k < 10; k++) begin
            n   = int'($urandom_range(0, 6));
            r   = int'($urandom_range(0, 4));
            rdy = 1'($urandom_range(0, 1));
            start_job(n, r, rdy, 0);
        end

        rand_rdy = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/anneal_step_sched.md
# anneal_step_sched

Sequencer for the energy-monitor step counter and the spin-update datapath. It accepts a job of `cfg_rounds_i` rounds of `cfg_iters_i` steps each and loads the step counter with the iteration target. It then issues one datapath step per valid/ready handshake and advances the counter on each accepted step. It reloads the counter between rounds and reports done or error. It sits between the top-level control registers and the counter/datapath pair.

## Interface
- COUNTER_BITWIDTH, 8: width of iteration count and counter value
- ROUND_BITWIDTH, 4: width of round count
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- cfg_valid_i  in  1  job request valid
- cfg_ready_o  out  1  job request ready; high only in IDLE
- cfg_iters_i  in  COUNTER_BITWIDTH  steps per round
- cfg_rounds_i  in  ROUND_BITWIDTH  number of rounds
- abort_i  in  1  abandon current job
- step_valid_o  out  1  step request to datapath
- step_ready_i  in  1  datapath accepts step
- cnt_en_o  out  1  counter enable; high whenever not IDLE
- cnt_load_o  out  1  counter load strobe
- cnt_value_o  out  COUNTER_BITWIDTH  counter load value; registered cfg_iters_i
- cnt_step_o  out  1  counter step strobe
- cnt_recount_o  out  1  counter recount (restart) strobe
- cnt_finish_i  in  1  counter reached target
- cnt_overflow_i  in  1  counter overflow
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse
- err_o  out  1  sticky error flag
- round_o  out  ROUND_BITWIDTH  rounds remaining, including the current round

## Operation
- States: IDLE, LOAD, ISSUE, CHECK, RECOUNT, DONE.
- IDLE: cfg_ready_o=1. On cfg_valid_i, latch iters and rounds, clear err_o, and go to LOAD. If iters==0 or rounds==0, go to DONE instead, with no counter or datapath activity.
- LOAD: cnt_load_o=1 for exactly one cycle, then go to ISSUE.
- ISSUE: step_valid_o=1, held until step_ready_i. On handshake, cnt_step_o=1 in the same cycle, then go to CHECK.
- CHECK: one cycle; the counter has updated.
  - cnt_finish_i=1 and round_o>1: go to RECOUNT.
  - cnt_finish_i=1 and round_o==1: go to DONE.
  - Otherwise: go to ISSUE.
- RECOUNT: cnt_recount_o=1 for one cycle, decrement round_o, then go to ISSUE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Overflow: cnt_overflow_i=1 in any state other than IDLE sets err_o and goes to DONE. That job has no further step, load or recount strobes.
- Abort: abort_i in any busy state goes to IDLE next cycle, with no done_o and err_o unchanged. If step_valid_o was high, it drops without a handshake. abort_i is ignored in IDLE.
- Priority in a single cycle: abort_i > cnt_overflow_i > normal transition. A handshake in the same cycle as abort_i does not produce cnt_step_o.
- busy_o is high in every state except IDLE.
- Strobes cnt_load_o, cnt_step_o and cnt_recount_o are mutually exclusive.

## Timing
- Reset: IDLE, cfg_ready_o=1, and every other output 0, including round_o and cnt_value_o.
- Reset asserted mid-job: everything returns immediately (asynchronously) to reset values. The job is lost.
- Job acceptance edge is T. LOAD runs in T+1. The first step_valid_o is in T+2.
- Step rate: at most one step per 2 cycles (ISSUE then CHECK) with step_ready_i tied high.
- Job latency with step_ready_i tied high and N, R ≥ 1: 1 + R·2N + (R−1) + 1 cycles from the acceptance edge to the done_o pulse.
- Zero job: done_o is asserted in the cycle after acceptance.
- cfg_ready_o returns high in the cycle after done_o.
- step_valid_o stays stable while step_ready_i is low.

## Test plan
- Basic: iters=3, rounds=1, step_ready_i=1 → 3 cnt_step_o pulses 2 cycles apart; cnt_load_o at T+1; done_o at T+8.
- Multi-round: iters=2, rounds=3 → 6 steps, 2 cnt_recount_o pulses, round_o 3→2→1; done_o at T+16; one load only.
- Backpressure: iters=4, step_ready_i randomly low 50% → step_valid_o held stable; exactly 4 handshakes and 4 cnt_step_o pulses; done_o once.
- Zero job: iters=0, rounds=5 → no load or step strobes; done_o at T+1; cfg_ready_o high at T+2.
- Overflow: force cnt_overflow_i during the 2nd ISSUE → err_o=1, done_o the next cycle, no further strobes. The next accepted job clears err_o.
- Abort and reset: abort_i during ISSUE with step_ready_i=1 → no cnt_step_o and no done_o; IDLE next cycle. rst_ni low mid-RECOUNT → all outputs at reset values immediately.
